// File: rtl/dewhitening_if.sv
// Serial-in / byte-out bundle between the bit-recovery front end, the dewhitener
// and the frame sink.
interface dewhitening_if;
  logic       trigger;
  logic       input_data;
  logic       output_dewhitening;
  logic       dewhite_valid;
  logic       sync_found;
  logic [7:0] frame_len;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_done;
  logic       frame_error;

  modport slave (
    input  trigger, input_data,
    output output_dewhitening, dewhite_valid, sync_found, frame_len,
           data_out, data_valid, frame_done, frame_error
  );

  modport master (
    output trigger, input_data,
    input  output_dewhitening, dewhite_valid, sync_found, frame_len,
           data_out, data_valid, frame_done, frame_error
  );
endinterface

// File: rtl/dewhitening.sv
// Self-synchronizing 7-bit descrambler followed by a sync/length/payload framer
// that packs payload bits MSB-first into bytes.
module dewhitening #(
  parameter logic [15:0] SYNC_WORD = 16'h2DD4
) (
  input  logic          clock,
  input  logic          reset,
  dewhitening_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, HUNT, LEN, PAYLOAD, DONE} state_t;

  state_t      state_q, state_d;
  logic [6:0]  scr_q;
  logic [15:0] hist_q;
  logic [4:0]  hunt_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  byte_cnt_q;

  logic        d_bit;
  logic [15:0] hist_next;
  logic [7:0]  byte_next;

  logic        sync_hit, len_cap, pay_cap, done_hit, err_hit;

  logic        out_bit_p1, vld_p1, sync_p1, dv_p1, done_p1, err_p1;
  logic [7:0]  len_p1, data_p1;

  // Counts bits seen since trigger rose; a match needs a full 16-bit history.
  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd16) ? v : v + 5'd1;
  endfunction

  assign d_bit     = bus.input_data ^ scr_q[3] ^ scr_q[6];
  assign hist_next = {hist_q[14:0], d_bit};
  assign byte_next = {shift_q[6:0], d_bit};

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    sync_hit = 1'b0;
    len_cap  = 1'b0;
    pay_cap  = 1'b0;
    done_hit = 1'b0;
    err_hit  = 1'b0;
    if (!bus.trigger) begin
      state_d = IDLE;
      err_hit = (state_q == LEN) || (state_q == PAYLOAD);
    end else begin
      case (state_q)
        IDLE: state_d = HUNT;
        HUNT: begin
          if (hunt_cnt_q >= 5'd15 && hist_next == SYNC_WORD) begin
            sync_hit = 1'b1;
            state_d  = LEN;
          end
        end
        LEN: begin
          if (bit_cnt_q == 3'd7) begin
            len_cap = 1'b1;
            if (byte_next == 8'd0) begin
              done_hit = 1'b1;
              state_d  = DONE;
            end else begin
              state_d = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (bit_cnt_q == 3'd7) begin
            pay_cap = 1'b1;
            if (byte_cnt_q == 8'd1) begin
              done_hit = 1'b1;
              state_d  = DONE;
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: descrambler/framer state update and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      scr_q      <= '0;
      hist_q     <= '0;
      hunt_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      out_bit_p1 <= 1'b0;
      vld_p1     <= 1'b0;
      sync_p1    <= 1'b0;
      dv_p1      <= 1'b0;
      done_p1    <= 1'b0;
      err_p1     <= 1'b0;
      len_p1     <= '0;
      data_p1    <= '0;
    end else begin
      vld_p1     <= bus.trigger;
      out_bit_p1 <= bus.trigger & d_bit;
      sync_p1    <= sync_hit;
      dv_p1      <= pay_cap;
      done_p1    <= done_hit;
      err_p1     <= err_hit;
      if (!bus.trigger) begin
        scr_q      <= '0;
        hist_q     <= '0;
        hunt_cnt_q <= '0;
        bit_cnt_q  <= '0;
        shift_q    <= '0;
        byte_cnt_q <= '0;
      end else begin
        // The received (scrambled) bit feeds the register, which makes it self-synchronizing.
        scr_q <= {scr_q[5:0], bus.input_data};
        if (state_q == IDLE || state_q == HUNT) begin
          hist_q     <= hist_next;
          hunt_cnt_q <= sat_inc(hunt_cnt_q);
        end
        if (sync_hit) begin
          bit_cnt_q <= '0;
          shift_q   <= '0;
        end else if (state_q == LEN || state_q == PAYLOAD) begin
          shift_q   <= byte_next;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        if (len_cap) begin
          len_p1     <= byte_next;
          byte_cnt_q <= byte_next;
        end
        if (pay_cap) begin
          data_p1    <= byte_next;
          byte_cnt_q <= byte_cnt_q - 8'd1;
        end
      end
    end
  end

  assign bus.output_dewhitening = out_bit_p1;
  assign bus.dewhite_valid      = vld_p1;
  assign bus.sync_found         = sync_p1;
  assign bus.frame_len          = len_p1;
  assign bus.data_out           = data_p1;
  assign bus.data_valid         = dv_p1;
  assign bus.frame_done         = done_p1;
  assign bus.frame_error        = err_p1;

endmodule

// File: tb/tb_dewhitening.sv
// Drives whitened frames through the dewhitener and checks every output cycle
// against a frame parser working directly on the plaintext bit stream.
module tb_dewhitening;

  logic clock;
  logic reset;
  dewhitening_if bus();

  dewhitening dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  bit         pq[$];
  bit         ev_sync[0:511];
  bit         ev_dv[0:511];
  bit         ev_done[0:511];
  logic [7:0] ev_byte[0:511];
  int         len_edge;
  logic [7:0] len_val;
  bit         ev_err_end;
  logic [7:0] exp_data;
  logic [7:0] exp_len;

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int j = 7; j >= 0; j--) pq.push_back(b[j]);
  endtask

  task automatic push_rand(input int n);
    for (int j = 0; j < n; j++) pq.push_back(bit'($urandom_range(0, 1)));
  endtask

  function automatic int first_sync(input int n);
    logic [15:0] w;
    for (int i = 15; i < n; i++) begin
      w = '0;
      for (int j = 0; j < 16; j++) w = {w[14:0], pq[i - 15 + j]};
      if (w == 16'h2DD4) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] byte_at(input int last);
    logic [7:0] v;
    v = '0;
    for (int j = 7; j >= 0; j--) v = {v[6:0], pq[last - j]};
    return v;
  endfunction

  // Frame parser: first sync ending at bit >= 15, then length byte, then payload bytes.
  task automatic model(input int n);
    int  s, e;
    bit  complete;
    for (int k = 0; k <= n; k++) begin
      ev_sync[k] = 0; ev_dv[k] = 0; ev_done[k] = 0; ev_byte[k] = '0;
    end
    len_edge   = -1;
    len_val    = '0;
    ev_err_end = 0;
    s = first_sync(n);
    if (s >= 0) begin
      ev_sync[s] = 1;
      complete   = 0;
      if (s + 8 <= n - 1) begin
        len_edge = s + 8;
        len_val  = byte_at(s + 8);
        if (len_val == 8'd0) begin
          ev_done[s + 8] = 1;
          complete = 1;
        end else begin
          for (int j = 0; j < int'(len_val); j++) begin
            e = s + 8 + 8 * (j + 1);
            if (e <= n - 1) begin
              ev_dv[e]   = 1;
              ev_byte[e] = byte_at(e);
              if (j == int'(len_val) - 1) begin
                ev_done[e] = 1;
                complete = 1;
              end
            end
          end
        end
      end
      ev_err_end = !complete;
    end
  endtask

  task automatic run_window(input bit use_reset);
    int         n;
    logic [6:0] t;
    bit         y;
    bit         r[$];
    n = pq.size();
    model(n);
    t = '0;
    r = {};
    for (int k = 0; k < n; k++) begin
      y = pq[k] ^ t[3] ^ t[6];
      r.push_back(y);
      t = {t[5:0], y};
    end
    for (int k = 0; k <= n; k++) begin
      if (k < n) begin
        bus.trigger = 1'b1; bus.input_data = r[k];
      end else if (use_reset) begin
        reset = 1'b1; bus.trigger = 1'b1; bus.input_data = 1'b1;
      end else begin
        bus.trigger = 1'b0; bus.input_data = 1'b0;
      end
      @(posedge clock); #1;
      if (k < n) begin
        if (ev_dv[k]) exp_data = ev_byte[k];
        if (k == len_edge) exp_len = len_val;
        check1("dewhite_valid", bus.dewhite_valid, 1'b1);
        check1("dewhite_bit", bus.output_dewhitening, pq[k]);
        check1("sync_found", bus.sync_found, ev_sync[k]);
        check1("data_valid", bus.data_valid, ev_dv[k]);
        check1("frame_done", bus.frame_done, ev_done[k]);
        check1("frame_error", bus.frame_error, 1'b0);
        check8("data_out", bus.data_out, exp_data);
        check8("frame_len", bus.frame_len, exp_len);
      end else if (use_reset) begin
        exp_data = '0;
        exp_len  = '0;
        check1("rst_valid", bus.dewhite_valid, 1'b0);
        check1("rst_bit", bus.output_dewhitening, 1'b0);
        check1("rst_sync", bus.sync_found, 1'b0);
        check1("rst_dv", bus.data_valid, 1'b0);
        check1("rst_done", bus.frame_done, 1'b0);
        check1("rst_err", bus.frame_error, 1'b0);
        check8("rst_data", bus.data_out, 8'h00);
        check8("rst_len", bus.frame_len, 8'h00);
        reset = 1'b0; bus.trigger = 1'b0; bus.input_data = 1'b0;
        @(posedge clock); #1;
        check1("post_rst_err", bus.frame_error, 1'b0);
        check1("post_rst_valid", bus.dewhite_valid, 1'b0);
      end else begin
        check1("end_valid", bus.dewhite_valid, 1'b0);
        check1("end_sync", bus.sync_found, 1'b0);
        check1("end_dv", bus.data_valid, 1'b0);
        check1("end_done", bus.frame_done, 1'b0);
        check1("end_err", bus.frame_error, ev_err_end);
        check8("end_data", bus.data_out, exp_data);
        check8("end_len", bus.frame_len, exp_len);
      end
    end
  endtask

  initial begin
    logic [11:0] imp;
    int          plen;
    imp = 12'b1000_1001_0000;
    exp_data = '0;
    exp_len  = '0;
    reset = 1'b1;
    bus.trigger = 1'b0;
    bus.input_data = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check1("reset_valid", bus.dewhite_valid, 1'b0);
    check1("reset_sync", bus.sync_found, 1'b0);
    check1("reset_dv", bus.data_valid, 1'b0);
    check1("reset_done", bus.frame_done, 1'b0);
    check1("reset_err", bus.frame_error, 1'b0);
    check8("reset_len", bus.frame_len, 8'h00);
    check8("reset_data", bus.data_out, 8'h00);
    reset = 1'b0;
    @(posedge clock); #1;

    // Impulse response of the descrambler on a raw input stream
    for (int k = 0; k < 12; k++) begin
      bus.trigger = 1'b1;
      bus.input_data = (k == 0);
      @(posedge clock); #1;
      check1("imp_valid", bus.dewhite_valid, 1'b1);
      check1("imp_bit", bus.output_dewhitening, imp[11 - k]);
      check1("imp_sync", bus.sync_found, 1'b0);
    end
    bus.trigger = 1'b0;
    bus.input_data = 1'b0;
    @(posedge clock); #1;
    check1("imp_end_err", bus.frame_error, 1'b0);

    // Directed loopback frame
    pq = {};
    push_byte(8'h2D); push_byte(8'hD4); push_byte(8'h03);
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    run_window(1'b0);

    // Random loopback frames
    for (int f = 0; f < 3; f++) begin
      pq = {};
      push_rand($urandom_range(0, 20));
      push_byte(8'h2D); push_byte(8'hD4);
      plen = $urandom_range(1, 5);
      push_byte(8'(plen));
      for (int b = 0; b < plen; b++) push_byte(8'($urandom));
      push_rand($urandom_range(0, 10));
      run_window(1'b0);
    end

    // Zero length with trailing bits
    pq = {};
    push_rand(5);
    push_byte(8'h2D); push_byte(8'hD4); push_byte(8'h00);
    push_rand(20);
    run_window(1'b0);

    // Truncated frame, then a normal one
    pq = {};
    push_byte(8'h2D); push_byte(8'hD4); push_byte(8'h04);
    push_byte(8'($urandom)); push_byte(8'($urandom));
    push_rand(3);
    run_window(1'b0);
    pq = {};
    push_byte(8'h2D); push_byte(8'hD4); push_byte(8'h02);
    push_byte(8'h5A); push_byte(8'h3C);
    run_window(1'b0);

    // Long stream with no sync
    do begin
      pq = {};
      push_rand(200);
    end while (first_sync(200) >= 0);
    run_window(1'b0);

    // Reset mid-payload, then a normal frame
    pq = {};
    push_byte(8'h2D); push_byte(8'hD4); push_byte(8'h05);
    push_byte(8'($urandom)); push_byte(8'($urandom));
    push_rand(4);
    run_window(1'b1);
    pq = {};
    push_rand(7);
    push_byte(8'h2D); push_byte(8'hD4); push_byte(8'h03);
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    push_rand(6);
    run_window(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
